irq_arbiter: RTL

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Edge-triggered interrupt arbiter with an MMIO pending/enable/claim register file.
// Define IRQ_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module irq_arbiter #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic [3:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    output logic            eip,
    input  logic            eip_reply
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CLAIMED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [4:0]      claim_q, claim_d;
    logic            eip_q, eip_d;

    logic [NSRC-1:0] edge_s;
    logic [NSRC-1:0] req_s;
    logic [NSRC-1:0] grant_mask_s;
    logic [4:0]      winner_s;
    logic            grant_s;
    logic            cpl_s;
    logic            unused_d_s;

    assign unused_d_s = ^d;
    assign edge_s     = irq_in & ~irq_q;
    assign req_s      = pending_q & enable_q;
    assign cpl_s      = we && (a == 4'h8) && (d[4:0] == claim_q) && (state_q == CLAIMED);

`ifdef IRQ_ARB_RR_EN
    logic [4:0] ptr_q;

    // First requester strictly above the last winner, else the lowest requester (wrap).
    function automatic logic [4:0] pick_rr(input logic [NSRC-1:0] r, input logic [4:0] last);
        logic [4:0] lo;
        logic [4:0] hi;
        logic       hi_vld;
        lo     = 5'd0;
        hi     = 5'd0;
        hi_vld = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            lo     = r[i] ? 5'(i) : lo;
            hi     = (r[i] && (5'(i) > last)) ? 5'(i) : hi;
            hi_vld = hi_vld | (r[i] && (5'(i) > last));
        end
        return hi_vld ? hi : lo;
    endfunction

    assign winner_s = pick_rr(req_s, ptr_q);

    // Last granted index; moves only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 5'd0;
        end else if (grant_s) begin
            ptr_q <= winner_s;
        end else begin
            ptr_q <= ptr_q;
        end
    end
`else
    function automatic logic [4:0] pick_fixed(input logic [NSRC-1:0] r);
        logic [4:0] w;
        w = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            w = r[i] ? 5'(i) : w;
        end
        return w;
    endfunction

    assign winner_s = pick_fixed(req_s);
`endif

    // Grant/acknowledge/completion sequencing.
    always_comb begin
        state_d = state_q;
        claim_d = claim_q;
        eip_d   = eip_q;
        grant_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s != '0) begin
                    grant_s = 1'b1;
                    claim_d = winner_s + 5'd1;
                    eip_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    eip_d   = 1'b0;
                end
            end
            REQ: begin
                if (eip_reply) begin
                    eip_d   = 1'b0;
                    state_d = CLAIMED;
                end else begin
                    eip_d   = 1'b1;
                end
            end
            CLAIMED: begin
                eip_d = 1'b0;
                if (cpl_s) begin
                    claim_d = 5'd0;
                    state_d = IDLE;
                end else begin
                    state_d = CLAIMED;
                end
            end
            default: begin
                state_d = IDLE;
                claim_d = 5'd0;
                eip_d   = 1'b0;
            end
        endcase
    end

    // A new edge on the source being granted wins over the grant's clear.
    always_comb begin
        grant_mask_s = grant_s ? (NSRC'(1'b1) << winner_s) : '0;
        pending_d    = (pending_q & ~grant_mask_s) | edge_s;
        if (we && (a == 4'h4)) begin
            enable_d = d[NSRC-1:0];
        end else begin
            enable_d = enable_q;
        end
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            claim_q   <= 5'd0;
            eip_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_in;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            claim_q   <= claim_d;
            eip_q     <= eip_d;
        end
    end

    assign eip = eip_q;

    // MMIO read mux; unused bits and undecoded addresses read zero.
    always_comb begin
        spo = 32'd0;
        case (a)
            4'h0:    spo[NSRC-1:0] = pending_q;
            4'h4:    spo[NSRC-1:0] = enable_q;
            4'h8:    spo[4:0]      = claim_q;
            default: spo           = 32'd0;
        endcase
    end

endmodule
